pipeline_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline. Drives the 2-bit condition code of

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/hazard_detect.sv | 15 +
 rtl/pipeline_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer: stage-register
// condition codes, sequencer states and the per-stage condition bundle.
package pipe_pkg;

    localparam logic [1:0] COND_FLUSH = 2'd0;
    localparam logic [1:0] COND_LOAD  = 2'd1;
    localparam logic [1:0] COND_HOLD  = 2'd2;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic [1:0] pc;
        logic [1:0] ifid;
        logic [1:0] idex;
        logic [1:0] exmem;
        logic [1:0] memwb;
    } cond_vec_t;

    function automatic cond_vec_t cond_vec(input logic [1:0] pc, input logic [1:0] ifid,
                                           input logic [1:0] idex, input logic [1:0] exmem,
                                           input logic [1:0] memwb);
        cond_vec_t v;
        v.pc    = pc;
        v.ifid  = ifid;
        v.idex  = idex;
        v.exmem = exmem;
        v.memwb = memwb;
        return v;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: the load in EX writes a register the ID
// instruction is about to read. Register 0 is hardwired and never hazards.
module hazard_detect (
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    input  logic       ifid_uses_rt,
    input  logic       idex_memread,
    input  logic [4:0] idex_rt,
    output logic       load_use
);

    assign load_use = idex_memread & (idex_rt != 5'd0) &
                      ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: per-stage condition codes,
// memory-wait watchdog and saturating stall/redirect counters.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic             branch_taken,
    input  logic             jump_id,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             dmem_ready,
    output logic [1:0]       pc_cond,
    output logic [1:0]       ifid_cond,
    output logic [1:0]       idex_cond,
    output logic [1:0]       exmem_cond,
    output logic [1:0]       memwb_cond,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO  = WAIT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO   = CNT_W'(0);

    pipe_state_t       state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_err_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic      mem_stall_s;
    logic      load_use_s;
    logic      err_s;
    logic      stall_evt_s;
    logic      flush_evt_s;
    cond_vec_t cond_s;

    assign mem_stall_s = (exmem_memread | exmem_memwrite) & ~dmem_ready;
    // Any encoding other than RUN/MEM_WAIT is treated as the fail-safe frozen state.
    assign err_s       = (state_r != RUN) && (state_r != MEM_WAIT);

    hazard_detect u_hazard_detect (
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .load_use     (load_use_s)
    );

    // Priority mux for stage conditions; a memory stall masks redirects and hazards,
    // which the held EX/ID registers re-present once memory completes.
    always_comb begin
        cond_s      = cond_vec(COND_FLUSH, COND_FLUSH, COND_FLUSH, COND_FLUSH, COND_FLUSH);
        stall_evt_s = 1'b0;
        flush_evt_s = 1'b0;
        if (!reset) begin
            cond_s = cond_vec(COND_FLUSH, COND_FLUSH, COND_FLUSH, COND_FLUSH, COND_FLUSH);
        end else if (err_s) begin
            cond_s      = cond_vec(COND_HOLD, COND_HOLD, COND_HOLD, COND_HOLD, COND_HOLD);
            stall_evt_s = 1'b1;
        end else if (mem_stall_s) begin
            cond_s      = cond_vec(COND_HOLD, COND_HOLD, COND_HOLD, COND_HOLD, COND_FLUSH);
            stall_evt_s = 1'b1;
        end else if (branch_taken) begin
            cond_s      = cond_vec(COND_LOAD, COND_FLUSH, COND_FLUSH, COND_LOAD, COND_LOAD);
            flush_evt_s = 1'b1;
        end else if (load_use_s) begin
            cond_s      = cond_vec(COND_HOLD, COND_HOLD, COND_FLUSH, COND_LOAD, COND_LOAD);
            stall_evt_s = 1'b1;
        end else if (jump_id) begin
            cond_s      = cond_vec(COND_LOAD, COND_FLUSH, COND_LOAD, COND_LOAD, COND_LOAD);
            flush_evt_s = 1'b1;
        end else begin
            cond_s      = cond_vec(COND_LOAD, COND_LOAD, COND_LOAD, COND_LOAD, COND_LOAD);
        end
    end

    // Sequencer FSM, memory-wait watchdog and saturating performance counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= RUN;
            wait_cnt_r  <= WAIT_ZERO;
            mem_err_r   <= 1'b0;
            stall_cnt_r <= CNT_ZERO;
            flush_cnt_r <= CNT_ZERO;
        end else begin
            if (stall_evt_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end
            if (flush_evt_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end
            case (state_r)
                RUN: begin
                    if (mem_stall_s) begin
                        state_r    <= MEM_WAIT;
                        wait_cnt_r <= WAIT_ONE;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall_s) begin
                        state_r    <= RUN;
                        wait_cnt_r <= WAIT_ZERO;
                    end else if (wait_cnt_r == WAIT_LIMIT) begin
                        state_r   <= ERR;
                        mem_err_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_ONE;
                    end
                end
                ERR: begin
                    mem_err_r <= 1'b1;
                end
                default: begin
                    state_r   <= ERR;
                    mem_err_r <= 1'b1;
                end
            endcase
        end
    end

    assign pc_cond    = cond_s.pc;
    assign ifid_cond  = cond_s.ifid;
    assign idex_cond  = cond_s.idex;
    assign exmem_cond = cond_s.exmem;
    assign memwb_cond = cond_s.memwb;
    assign mem_err    = mem_err_r;
    assign stall_cnt  = stall_cnt_r;
    assign flush_cnt  = flush_cnt_r;

endmodule
